// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue; entry 0 is always the head so outputs come straight from flops.
module fetch_fifo
  import cpu_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t ent0, ent1, ent0_n, ent1_n;
  logic [1:0]   cnt, cnt_n;
  logic         do_pop, do_push;

  always_comb begin
    ent0_n  = ent0;
    ent1_n  = ent1;
    cnt_n   = cnt;
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && (do_pop || (cnt != 2'd2));
    if (do_pop) begin
      ent0_n = ent1;
      cnt_n  = cnt - 2'd1;
    end
    // Push lands in the first free slot after the pop has shifted.
    if (do_push) begin
      if (cnt_n == 2'd0) ent0_n = din;
      else               ent1_n = din;
      cnt_n = cnt_n + 2'd1;
    end
    if (flush) cnt_n = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      ent0 <= ent0_n;
      ent1 <= ent1_n;
      cnt  <= cnt_n;
    end
  end

  assign head  = ent0;
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC, fetch FSM, synchronous instruction memory and in-flight tracking feeding a 2-entry fetch queue.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [INSTR_W-1:0]             load_data,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [INSTR_W-1:0]             instruction_word,
  output logic [31:0]                    instr_pc,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic                           busy,
  output logic                           fault,
  output logic [31:0]                    fault_pc
);

  localparam int AW = $clog2(DEPTH_WORDS);

  fetch_state_e       state, state_n;
  logic [31:0]        pc, pc_n, fault_pc_n, rd_pc_q;
  logic               rd_pend, rd_issue, flush, load_we, pop, pc_oor;
  logic [1:0]         fifo_cnt;
  logic [2:0]         credit;
  logic [INSTR_W-1:0] mem [DEPTH_WORDS];
  logic [INSTR_W-1:0] mem_q;
  fetch_entry_t       head, rd_ent;

  assign pop    = instr_valid && instr_ready;
  assign pc_oor = (pc >> (2 + AW)) != 32'd0;
  // Counting the head that leaves this edge keeps one fetch per cycle under a steady ready.
  assign credit = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fault_pc_n = fault_pc;
    rd_issue   = 1'b0;
    flush      = 1'b0;
    load_we    = 1'b0;
    case (state)
      IDLE: begin
        load_we = load_en;
        if (start) begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            state_n    = FAULT;
            fault_pc_n = redirect_pc;
          end else begin
            pc_n = redirect_pc;
          end
        end else if (credit < 3'd2) begin
          if (pc_oor) begin
            state_n    = FAULT;
            fault_pc_n = pc;
          end else begin
            rd_issue = 1'b1;
            pc_n     = pc + 32'd4;
          end
        end
      end
      FAULT: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fault_pc <= '0;
      rd_pend  <= 1'b0;
      rd_pc_q  <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fault_pc <= fault_pc_n;
      rd_pend  <= rd_issue;
      if (rd_issue) rd_pc_q <= pc;
    end
  end

  // Memory is deliberately left out of reset so preloaded programs survive it.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (rd_issue) mem_q <= mem[pc[2+AW-1:2]];
  end

  assign rd_ent = '{pc: rd_pc_q, instr: mem_q};

  // A read landing on a redirect edge is dropped by the flush.
  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (rd_pend),
    .din   (rd_ent),
    .pop   (pop),
    .head  (head),
    .valid (instr_valid),
    .count (fifo_cnt)
  );

  assign instruction_word = head.instr;
  assign instr_pc         = head.pc;
  assign busy             = (state != IDLE);
  assign fault            = (state == FAULT);

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-supply side of the core: owns the program counter and instruction memory and streams 32-bit instruction words to `DataPath` over a valid/ready handshake. It sits in front of `DataPath`'s `instruction_word` input. The datapath redirects the PC on taken branches and jumps, and the block reports fetch faults. Memory is preloaded through a load port while idle, so benches and boot code fill it before `start`.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: instruction memory depth in 32-bit words; power of two.
- `RESET_PC`, 32'h0000_0000: PC loaded at reset; word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  leave IDLE and begin fetching at `RESET_PC`. Honoured only in IDLE.
- `load_en`  in  1  write `load_data` to memory word `load_addr`. Honoured only in IDLE.
- `load_addr`  in  $clog2(DEPTH_WORDS)  word address for preload.
- `load_data`  in  32  preload data.
- `instr_valid`  out  1  `instruction_word` / `instr_pc` hold a fetched instruction.
- `instr_ready`  in  1  datapath accepts the instruction this cycle.
- `instruction_word`  out  32  fetched instruction.
- `instr_pc`  out  32  byte address of `instruction_word`.
- `redirect_valid`  in  1  datapath requests a PC change; single-cycle pulse.
- `redirect_pc`  in  32  new byte PC.
- `busy`  out  1  state is not IDLE.
- `fault`  out  1  sticky fetch fault.
- `fault_pc`  out  32  PC that caused the fault.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - FAULT: left only by reset.
- IDLE -> RUN on `start`. RUN -> FAULT on a misaligned redirect or an out-of-range fetch.
- Memory: `DEPTH_WORDS` x 32, synchronous read, 1-cycle latency. Contents are not cleared by reset.
- Word index is `pc[2+$clog2(DEPTH_WORDS)-1:2]`.
- RUN issues one read per cycle at PC when (FIFO occupancy + reads in flight) < 2. The PC then advances by 4, wrapping modulo 2^32.
- Returned words enter a 2-entry FIFO of {pc, instr}. The FIFO head drives `instruction_word`, `instr_pc` and `instr_valid`.
- A transfer occurs on an edge with `instr_valid && instr_ready`. The head pops; the next entry or an arriving word appears the following cycle.
- `instr_valid` is never withdrawn without a transfer, except on redirect or reset.
- Redirect in RUN with `redirect_pc[1:0]==0`:
  - FIFO flushed and the in-flight read discarded.
  - PC <= `redirect_pc`; fetch resumes at the new PC.
  - A transfer on the same edge still completes; the flush applies afterwards.
- Redirect with `redirect_pc[1:0]!=0`: FAULT, `fault_pc <= redirect_pc`, FIFO flushed.
- Out-of-range fetch (PC word index >= `DEPTH_WORDS`, i.e. `pc[31:2+log2]`!=0):
  - No read is issued; go to FAULT with `fault_pc <= pc`.
  - Entries already in the FIFO still drain normally.
- In FAULT: no new reads; `redirect_valid`, `start` and `load_en` are ignored.
- `load_en` together with `start` on the same IDLE edge: the write completes and the first fetch reads the new data.
- Outside IDLE, `load_en` and `start` are ignored.

## Timing
- Reset values: `instr_valid` 0, `instruction_word` 0, `instr_pc` 0, `busy` 0, `fault` 0, `fault_pc` 0, PC `RESET_PC`, FIFO empty.
- Reset asserted mid-operation clears all of the above on that edge.
- Startup latency: `start` sampled at edge E0, read issued in the cycle after E0, `instr_valid` high after edge E2.
- Throughput: one instruction per cycle with `instr_ready` held high.
- Redirect sampled at edge R: `instr_valid` low after R; the first redirected instruction is valid after edge R+2.
- `fault` and `busy` change on the edge that takes the transition.
- No combinational path from `instr_ready` or `redirect_valid` to any output.

## Structure
- Package `cpu_fetch_pkg`:
  - state enum {IDLE, RUN, FAULT}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `INSTR_W` = 32.
  - {pc, instr} fetch-entry struct.
- Sub-module `fetch_fifo`: 2-entry FIFO with flush, push/pop, occupancy count. Push and pop on the same edge are allowed at any occupancy.
- Top-level holds the PC, the FSM, in-flight tracking and the memory array.

## Test plan
- Preload words 0..3 = 32'h00107093, 32'h00107093, 32'h0010F013, 32'h00100033; `start` with `instr_ready`=1 -> four consecutive transfers with PCs 0, 4, 8, 12; first valid after edge E2.
- Same program with `instr_ready` low for 3 cycles after first valid -> `instruction_word` holds 32'h00107093 / PC 0 stable; no drops or duplicates; order unchanged after release.
- Redirect to 32'h0000_000C while the FIFO is full -> queued entries discarded; after edge R+2, `instr_pc`=12, `instruction_word`=32'h00100033.
- Redirect to 32'h0000_0006 -> `fault`=1, `fault_pc`=6, `instr_valid` low and stays low; a later redirect or `start` has no effect.
- `DEPTH_WORDS`=4, run sequentially -> 4 instructions delivered, then `fault`=1 with `fault_pc`=16.
- `rst` low mid-stream -> all outputs at reset values next cycle; `load_en` while busy does not change memory (verified by reload plus fetch after reset).
